dec_mpp_seq: RTL and testbench

- Controller for the shared midpoint-prediction (MPP) reconstruction datapath in the decoder.
- Accepts one coded block at a time and issues NUM_COMP component passes (Y, Co, Cg) to the single datapath.
- Stores each component's reconstructed 16-sample block as that component's prev_rec for the next block.
- Maintains the per-slice block counter and first-block flag, and streams results downstream with valid/ready backpressure.

---
 rtl/dec_mpp_seq.sv | 157 +++++++++++++++
 tb/tb_dec_mpp_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dec_mpp_seq.sv
// MPP reconstruction controller: issues NUM_COMP datapath passes per coded block and keeps per-component prev_rec.
// Optional macro DEC_MPP_TIMEOUT_EN adds a dp_done watchdog with a sticky err flag.
module dec_mpp_seq #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned NUM_COMP = 3,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  slice_start,
  input  logic                  blk_vld,
  output logic                  blk_rdy,
  input  logic [3:0]            step_y,
  input  logic [3:0]            step_c,
  output logic                  dp_start,
  output logic [1:0]            dp_comp,
  output logic                  dp_first,
  output logic [3:0]            dp_step,
  output logic [16*DEPTH-1:0]   dp_prev,
  input  logic                  dp_done,
  input  logic [16*DEPTH-1:0]   dp_rec,
  output logic                  rec_vld,
  input  logic                  rec_rdy,
  output logic [1:0]            rec_comp,
  output logic [16*DEPTH-1:0]   rec_data,
  output logic [15:0]           blk_cnt,
  output logic                  err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  localparam logic [1:0]       LastComp = 2'(NUM_COMP - 1);
  localparam logic [DEPTH-1:0] Mid      = {1'b1, {(DEPTH-1){1'b0}}};

  state_t              state, stateNext;
  logic [3:0]          stepY, stepC;
  logic [1:0]          comp;
  logic [15:0]         blkCnt;
  logic                firstPend;
  logic [16*DEPTH-1:0] recData;
  logic [1:0]          recComp;
  logic [16*DEPTH-1:0] prevStore [NUM_COMP];
  logic                accept, capture, advance, timeoutHit;

`ifdef DEC_MPP_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer;
  logic          errQ;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    accept     = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    timeoutHit = 1'b0;
    case (state)
      IDLE: if (blk_vld) begin
        accept    = 1'b1;
        stateNext = ISSUE;
      end
      // a zero-latency datapath answers while dp_start is still high
      ISSUE: if (dp_done) begin
        capture   = 1'b1;
        stateNext = OUT;
      end else begin
        stateNext = WAIT;
      end
      WAIT: if (dp_done) begin
        capture   = 1'b1;
        stateNext = OUT;
      end
`ifdef DEC_MPP_TIMEOUT_EN
      else if (timer == TW'(TIMEOUT - 1)) begin
        timeoutHit = 1'b1;
        stateNext  = OUT;
      end
`endif
      OUT: if (rec_rdy) begin
        if (comp == LastComp) begin
          stateNext = IDLE;
        end else begin
          advance   = 1'b1;
          stateNext = ISSUE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stepY     <= '0;
      stepC     <= '0;
      comp      <= '0;
      blkCnt    <= '0;
      firstPend <= 1'b1;
      recData   <= '0;
      recComp   <= '0;
      for (int unsigned i = 0; i < NUM_COMP; i++) prevStore[i] <= '0;
    end else begin
      if (accept) begin
        stepY     <= step_y;
        stepC     <= step_c;
        comp      <= '0;
        blkCnt    <= (firstPend || slice_start) ? 16'd1
                   : (blkCnt == '1) ? blkCnt : blkCnt + 16'd1;
        firstPend <= 1'b0;
      end else if (slice_start) begin
        firstPend <= 1'b1;
      end
      if (advance) comp <= comp + 2'd1;
      if (capture) begin
        recData         <= dp_rec;
        prevStore[comp] <= dp_rec;
        recComp         <= comp;
      end else if (timeoutHit) begin
        recData         <= {16{Mid}};
        prevStore[comp] <= {16{Mid}};
        recComp         <= comp;
      end
    end
  end

`ifdef DEC_MPP_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timer <= '0;
      errQ  <= 1'b0;
    end else begin
      if (state == ISSUE)     timer <= '0;
      else if (state == WAIT) timer <= timer + 1'b1;
      if (timeoutHit) errQ <= 1'b1;
    end
  end
  assign err = errQ;
`else
  assign err = 1'b0;
`endif

  assign blk_rdy  = (state == IDLE);
  assign dp_start = (state == ISSUE);
  assign rec_vld  = (state == OUT);
  assign dp_comp  = comp;
  assign dp_step  = (comp == 2'd0) ? stepY : stepC;
  assign dp_first = (blkCnt == 16'd1);
  assign dp_prev  = prevStore[comp];
  assign rec_comp = recComp;
  assign rec_data = recData;
  assign blk_cnt  = blkCnt;

endmodule

// File: tb/tb_dec_mpp_seq.sv
// Self-checking bench for dec_mpp_seq: behavioural slice/prev_rec model, randomized latency, stalls and steps.
module tb_dec_mpp_seq;

  localparam int NC = 3;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         slice_start = 1'b0;
  logic         blk_vld = 1'b0;
  logic         blk_rdy;
  logic [3:0]   step_y = '0;
  logic [3:0]   step_c = '0;
  logic         dp_start;
  logic [1:0]   dp_comp;
  logic         dp_first;
  logic [3:0]   dp_step;
  logic [127:0] dp_prev;
  logic         dp_done = 1'b0;
  logic [127:0] dp_rec = '0;
  logic         rec_vld;
  logic         rec_rdy = 1'b0;
  logic [1:0]   rec_comp;
  logic [127:0] rec_data;
  logic [15:0]  blk_cnt;
  logic         err;

  int checks = 0;
  int errors = 0;

  // reference model: what the slice bookkeeping and prev_rec memory should hold
  logic [127:0] mPrev [NC];
  int           mCnt;
  bit           mFirstPend;

  dec_mpp_seq #(.DEPTH(8), .NUM_COMP(NC), .TIMEOUT(64)) dut (
    .clk(clk), .rstn(rstn), .slice_start(slice_start), .blk_vld(blk_vld), .blk_rdy(blk_rdy),
    .step_y(step_y), .step_c(step_c), .dp_start(dp_start), .dp_comp(dp_comp), .dp_first(dp_first),
    .dp_step(dp_step), .dp_prev(dp_prev), .dp_done(dp_done), .dp_rec(dp_rec), .rec_vld(rec_vld),
    .rec_rdy(rec_rdy), .rec_comp(rec_comp), .rec_data(rec_data), .blk_cnt(blk_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NC; i++) mPrev[i] = '0;
    mCnt = 0;
    mFirstPend = 1'b1;
  endtask

  // Drives one block through all passes; abortAt >= 0 asserts reset in that pass's first WAIT cycle.
  task automatic do_block(input bit slice, input logic [3:0] sy, input logic [3:0] sc,
                          input int lat, input int stall, input bit midSlice,
                          input int abortAt, output int nEdges);
    logic [127:0] rec;
    logic [3:0]   expStep;
    int           expCnt;
    expCnt = (mFirstPend || slice) ? 1 : ((mCnt >= 65535) ? 65535 : mCnt + 1);
    nEdges = 0;
    checks++;
    if (blk_rdy !== 1'b1) begin errors++; $display("FAIL blk_rdy_idle got %b want 1", blk_rdy); end
    blk_vld = 1'b1; slice_start = slice; step_y = sy; step_c = sc;
    @(negedge clk); nEdges++;
    blk_vld = 1'b0; slice_start = 1'b0; step_y = 4'($urandom); step_c = 4'($urandom);
    mCnt = expCnt; mFirstPend = 1'b0;
    checks++;
    if (blk_cnt !== 16'(expCnt) || blk_rdy !== 1'b0) begin
      errors++; $display("FAIL accept blk_cnt=%0d blk_rdy=%b want %0d 0", blk_cnt, blk_rdy, expCnt);
    end
    for (int c = 0; c < NC; c++) begin
      expStep = (c == 0) ? sy : sc;
      checks++;
      if (dp_start !== 1'b1 || dp_comp !== 2'(c) || dp_step !== expStep ||
          dp_first !== (expCnt == 1) || dp_prev !== mPrev[c]) begin
        errors++;
        $display("FAIL issue c%0d start=%b comp=%0d step=%0d first=%b prev=%h want 1 %0d %0d %b %h",
                 c, dp_start, dp_comp, dp_step, dp_first, dp_prev, c, expStep, expCnt == 1, mPrev[c]);
      end
      rec = {$urandom, $urandom, $urandom, $urandom};
      if (lat == 0) begin dp_done = 1'b1; dp_rec = rec; end
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk); nEdges++;
        slice_start = 1'b0;
        if (c == abortAt) begin rstn = 1'b0; return; end
        if (midSlice && c == 0 && k == 1) begin slice_start = 1'b1; mFirstPend = 1'b1; end
        checks++;
        if (dp_start !== 1'b0 || dp_comp !== 2'(c) || dp_step !== expStep ||
            dp_prev !== mPrev[c] || rec_vld !== 1'b0) begin
          errors++;
          $display("FAIL wait_hold c%0d start=%b comp=%0d step=%0d rec_vld=%b", c, dp_start, dp_comp, dp_step, rec_vld);
        end
        if (k == lat) begin dp_done = 1'b1; dp_rec = rec; end
      end
      @(negedge clk); nEdges++;
      dp_done = 1'b0; slice_start = 1'b0; dp_rec = {$urandom, $urandom, $urandom, $urandom};
      for (int s = 0; s < stall; s++) begin
        dp_done = 1'($urandom);
        checks++;
        if (rec_vld !== 1'b1 || rec_data !== rec || rec_comp !== 2'(c) || dp_start !== 1'b0) begin
          errors++;
          $display("FAIL stall c%0d vld=%b data=%h comp=%0d start=%b want 1 %h %0d 0", c, rec_vld, rec_data, rec_comp, dp_start, rec, c);
        end
        @(negedge clk); nEdges++;
      end
      dp_done = 1'b0;
      checks++;
      if (rec_vld !== 1'b1 || rec_data !== rec || rec_comp !== 2'(c) || blk_rdy !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL out c%0d vld=%b data=%h comp=%0d rdy=%b err=%b want 1 %h %0d 0 0", c, rec_vld, rec_data, rec_comp, blk_rdy, err, rec, c);
      end
      rec_rdy = 1'b1; mPrev[c] = rec;
      @(negedge clk); nEdges++;
      rec_rdy = 1'b0;
    end
    checks++;
    if (blk_rdy !== 1'b1 || rec_vld !== 1'b0 || dp_start !== 1'b0) begin
      errors++; $display("FAIL block_end blk_rdy=%b rec_vld=%b dp_start=%b want 1 0 0", blk_rdy, rec_vld, dp_start);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (blk_rdy !== 1'b1 || dp_start !== 1'b0 || rec_vld !== 1'b0 || rec_comp !== 2'd0 ||
        rec_data !== 128'd0 || blk_cnt !== 16'd0 || err !== 1'b0 || dp_prev !== 128'd0) begin
      errors++;
      $display("FAIL reset rdy=%b start=%b vld=%b comp=%0d data=%h cnt=%0d err=%b", blk_rdy, dp_start, rec_vld, rec_comp, rec_data, blk_cnt, err);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_block();
    int n;
    do_block(1'b1, 4'd2, 4'd3, 2, 0, 1'b0, -1, n);
    checks++;
    if (n !== 13) begin errors++; $display("FAIL first_block_cycles got %0d want 13", n); end
  endtask

  task automatic test_second_block();
    int n;
    do_block(1'b0, 4'($urandom), 4'($urandom), 1, 0, 1'b0, -1, n);
    checks++;
    if (blk_cnt !== 16'd2) begin errors++; $display("FAIL second_cnt got %0d want 2", blk_cnt); end
  endtask

  task automatic test_backpressure();
    int n;
    do_block(1'b0, 4'($urandom), 4'($urandom), 0, 5, 1'b0, -1, n);
    do_block(1'b0, 4'($urandom), 4'($urandom), 3, 2, 1'b0, -1, n);
  endtask

  task automatic test_slice_restart();
    int n;
    do_block(1'b0, 4'($urandom), 4'($urandom), 2, 0, 1'b1, -1, n);
    do_block(1'b0, 4'($urandom), 4'($urandom), 2, 1, 1'b0, -1, n);
    checks++;
    if (blk_cnt !== 16'd1) begin errors++; $display("FAIL slice_restart_cnt got %0d want 1", blk_cnt); end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int b = 0; b < 24; b++) begin
      int lat;
      lat = $urandom_range(0, 4);
      do_block($urandom_range(0, 5) == 0, 4'($urandom), 4'($urandom), lat,
               $urandom_range(0, 3), (lat >= 2) && ($urandom_range(0, 5) == 0), -1, n);
    end
  endtask

  task automatic test_reset_midblock();
    int n;
    do_block(1'b0, 4'($urandom), 4'($urandom), 3, 0, 1'b0, 1, n);
    #1;
    checks++;
    if (rec_vld !== 1'b0 || blk_rdy !== 1'b1 || blk_cnt !== 16'd0 || dp_start !== 1'b0 ||
        rec_data !== 128'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL midblock_reset vld=%b rdy=%b cnt=%0d start=%b data=%h", rec_vld, blk_rdy, blk_cnt, dp_start, rec_data);
    end
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    do_block(1'b0, 4'($urandom), 4'($urandom), 1, 1, 1'b0, -1, n);
  endtask

`ifdef DEC_MPP_TIMEOUT_EN
  task automatic test_timeout();
    blk_vld = 1'b1; step_y = 4'd1; step_c = 4'd1;
    @(negedge clk);
    blk_vld = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 64) begin
        checks++;
        if (err !== 1'b0 || rec_vld !== 1'b0) begin
          errors++; $display("FAIL timeout_early err=%b vld=%b want 0 0", err, rec_vld);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || rec_vld !== 1'b1 || rec_data !== {16{8'h80}} || rec_comp !== 2'd0) begin
      errors++; $display("FAIL timeout err=%b vld=%b data=%h comp=%0d want 1 1 all80 0", err, rec_vld, rec_data, rec_comp);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL timeout_clear err=%b want 0", err); end
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_first_block();
    test_second_block();
    test_backpressure();
    test_slice_restart();
    test_back_to_back();
    test_reset_midblock();
`ifdef DEC_MPP_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
